icache_line_fill: RTL and testbench

- Refill engine upstream of the instruction cache.
- On a cache miss it fetches the whole 8-word line from a single-word, handshaked instruction memory, one outstanding read at a time.
- It assembles the words into a line buffer, then presents the full line to the cache for a one-cycle write.
- The fetch-side FSM uses `busy` as its PC stall source while a refill is in flight.

---
 rtl/icache_pkg.sv | 16 +
 rtl/icache_line_fill_line_buf.sv | 33 +++
 rtl/icache_line_fill.sv | 112 +++++++++++
 tb/tb_icache_line_fill.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared instruction-cache constants and refill FSM state encoding
package icache_pkg;

    localparam int WORDS_PER_LINE = 8;
    localparam int OFFSET_W       = 3;
    localparam int LINE_BYTES     = 32;
    localparam logic [31:0] NOP   = 32'h00000013;

    typedef enum logic [1:0] {
        FILL_IDLE = 2'd0,
        FILL_REQ  = 2'd1,
        FILL_WAIT = 2'd2,
        FILL_DONE = 2'd3
    } fill_state_t;

endpackage

// File: rtl/icache_line_fill_line_buf.sv
// rtl/icache_line_fill_line_buf.sv - single-write-port line buffer with packed read-out
module line_buf
    import icache_pkg::*;
#(
    parameter int WORDS  = 8,
    parameter int WORD_W = 32,
    parameter int IDX_W  = $clog2(WORDS)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    we,
    input  logic [IDX_W-1:0]        idx,
    input  logic [WORD_W-1:0]       wdata,
    output logic [WORDS*WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [WORDS];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[idx] <= wdata;
        end
    end

    for (genvar g = 0; g < WORDS; g++) begin : g_rd
        assign rdata[g*WORD_W +: WORD_W] = mem[g];
    end

endmodule

// File: rtl/icache_line_fill.sv
// rtl/icache_line_fill.sv - I-cache line refill engine; ICACHE_CRIT_WORD_FIRST_EN enables critical-word-first
module icache_line_fill
    import icache_pkg::*;
#(
    parameter int WORDS_PER_LINE = 8,
    parameter int ADDR_W         = 32,
    parameter int WORD_W         = 32
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             miss_req,
    input  logic [ADDR_W-1:0]                miss_addr,
    output logic                             busy,
    output logic                             fill_valid,
    output logic [ADDR_W-1:0]                fill_addr,
    output logic [WORDS_PER_LINE*WORD_W-1:0] fill_data,
    output logic                             crit_valid,
    output logic [WORD_W-1:0]                crit_data,
    output logic                             mem_req,
    output logic [ADDR_W-1:0]                mem_addr,
    input  logic                             mem_gnt,
    input  logic                             mem_rvalid,
    input  logic [WORD_W-1:0]                mem_rdata
);

    localparam int LW = $clog2(WORDS_PER_LINE);
    localparam int LO = LW + 2;
    localparam logic [LW-1:0] LAST_BEAT = LW'(WORDS_PER_LINE - 1);

    localparam logic [1:0] ST_IDLE = FILL_IDLE;
    localparam logic [1:0] ST_REQ  = FILL_REQ;
    localparam logic [1:0] ST_WAIT = FILL_WAIT;
    localparam logic [1:0] ST_DONE = FILL_DONE;

    logic [1:0]           state;
    logic [ADDR_W-LO-1:0] base_hi;
    logic [LW-1:0]        cnt;
    logic [LW-1:0]        beat;
    logic [LW-1:0]        start_off;
    logic                 buf_we;
    logic                 unused_addr;

`ifdef ICACHE_CRIT_WORD_FIRST_EN
    assign start_off = miss_addr[LO-1:2];
`else
    assign start_off = '0;
`endif
    assign unused_addr = &{1'b0, miss_addr[LO-1:0]};

    // cnt addresses the word; beat alone decides when the line is complete
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            base_hi <= '0;
            cnt     <= '0;
            beat    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (miss_req) begin
                        state   <= ST_REQ;
                        base_hi <= miss_addr[ADDR_W-1:LO];
                        cnt     <= start_off;
                        beat    <= '0;
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        cnt   <= cnt + 1'b1;
                        beat  <= beat + 1'b1;
                        state <= (beat == LAST_BEAT) ? ST_DONE : ST_REQ;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy       = (state != ST_IDLE);
    assign mem_req    = (state == ST_REQ);
    assign mem_addr   = mem_req ? {base_hi, cnt, 2'b00} : '0;
    assign fill_valid = (state == ST_DONE);
    assign fill_addr  = {base_hi, {LO{1'b0}}};
    assign buf_we     = (state == ST_WAIT) && mem_rvalid;

`ifdef ICACHE_CRIT_WORD_FIRST_EN
    assign crit_valid = buf_we && (beat == '0);
    assign crit_data  = crit_valid ? mem_rdata : '0;
`else
    assign crit_valid = 1'b0;
    assign crit_data  = '0;
`endif

    line_buf #(
        .WORDS  (WORDS_PER_LINE),
        .WORD_W (WORD_W),
        .IDX_W  (LW)
    ) u_line_buf (
        .CLK   (CLK),
        .RST   (RST),
        .we    (buf_we),
        .idx   (cnt),
        .wdata (mem_rdata),
        .rdata (fill_data)
    );

endmodule

// File: tb/tb_icache_line_fill.sv
// tb/tb_icache_line_fill.sv - directed scoreboard bench for icache_line_fill
module tb_icache_line_fill;

`ifdef ICACHE_CRIT_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         RST;
    logic         miss_req;
    logic [31:0]  miss_addr;
    logic         busy;
    logic         fill_valid;
    logic [31:0]  fill_addr;
    logic [255:0] fill_data;
    logic         crit_valid;
    logic [31:0]  crit_data;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_gnt;
    logic         mem_rvalid;
    logic [31:0]  mem_rdata;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] exp_addr_q[$];

    icache_line_fill dut (
        .CLK        (CLK),
        .RST        (RST),
        .miss_req   (miss_req),
        .miss_addr  (miss_addr),
        .busy       (busy),
        .fill_valid (fill_valid),
        .fill_addr  (fill_addr),
        .fill_data  (fill_data),
        .crit_valid (crit_valid),
        .crit_data  (crit_data),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " busy"}, 256'(busy), 256'(0));
        chk({tag, " mem_req"}, 256'(mem_req), 256'(0));
        chk({tag, " mem_addr"}, 256'(mem_addr), 256'(0));
        chk({tag, " fill_valid"}, 256'(fill_valid), 256'(0));
        chk({tag, " crit_valid"}, 256'(crit_valid), 256'(0));
    endtask

    // One line refill. dly_idx: word index whose grant is held off by dly cycles.
    // stray: inject a stray rvalid in REQ and a second miss_req while busy.
    // abort_beats: assert RST in the WAIT following that many returned words.
    task automatic run_line(input string tag, input logic [31:0] addr, input logic [31:0] dbase,
                            input int dly_idx, input int dly, input int exp_cyc,
                            input bit stray, input int abort_beats);
        logic [31:0]  base;
        logic [31:0]  gaddr;
        logic [255:0] exp_data;
        int  start, hold, beats, cyc;
        bit  pend, rv_now, done;

        base  = addr & 32'hFFFF_FFE0;
        start = CWF ? int'(addr[4:2]) : 0;
        exp_addr_q.delete();
        for (int i = 0; i < 8; i++) begin
            exp_addr_q.push_back(base + 32'(4 * ((start + i) % 8)));
        end
        exp_data = '0;
        for (int k = 0; k < 8; k++) begin
            exp_data[k*32 +: 32] = dbase + 32'(k);
        end

        miss_addr = addr;
        miss_req  = 1'b1;
        @(posedge CLK); #1;
        miss_req = 1'b0;
        cyc = 1; hold = 0; beats = 0; pend = 0; done = 0; gaddr = '0;

        while (!done && cyc <= 60) begin
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; miss_req = 1'b0;
            rv_now = pend;
            pend   = 1'b0;
            if (abort_beats > 0 && rv_now && beats == abort_beats) begin
                RST = 1'b1;
                @(posedge CLK); #1;
                RST = 1'b0;
                mem_rvalid = 1'b1;
                mem_rdata  = 32'h5555_5555;
                chk_idle_outputs({tag, " post-reset"});
                chk({tag, " post-reset fill_addr"}, 256'(fill_addr), 256'(0));
                chk({tag, " post-reset fill_data"}, fill_data, 256'(0));
                for (int c = 0; c < 6; c++) begin
                    @(posedge CLK); #1;
                    mem_rvalid = 1'b0;
                    chk({tag, " stale busy"}, 256'(busy), 256'(0));
                    chk({tag, " stale fill_valid"}, 256'(fill_valid), 256'(0));
                end
                chk({tag, " stale fill_data"}, fill_data, 256'(0));
                exp_addr_q.delete();
                return;
            end
            if (rv_now) begin
                mem_rvalid = 1'b1;
                mem_rdata  = dbase + 32'(gaddr[4:2]);
            end
            if (mem_req) begin
                if (exp_addr_q.size() == 0) begin
                    chk({tag, " unexpected mem_req"}, 256'(mem_req), 256'(0));
                end else begin
                    chk({tag, " mem_addr"}, 256'(mem_addr), 256'(exp_addr_q[0]));
                    if (hold >= ((int'(mem_addr[4:2]) == dly_idx) ? dly : 0)) begin
                        mem_gnt = 1'b1;
                        gaddr   = mem_addr;
                        void'(exp_addr_q.pop_front());
                        hold = 0;
                        pend = 1'b1;
                    end else begin
                        hold++;
                    end
                end
            end
            if (stray && cyc == 5 && mem_req && !rv_now) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hDEAD_BEEF;
            end
            if (stray && cyc == 6) begin
                miss_req  = 1'b1;
                miss_addr = 32'h0000_0300;
            end
            @(negedge CLK);
            chk({tag, " busy"}, 256'(busy), 256'(1));
            chk({tag, " crit_valid"}, 256'(crit_valid), 256'(CWF && rv_now && beats == 0));
            chk({tag, " crit_data"}, 256'(crit_data),
                256'((CWF && rv_now && beats == 0) ? (dbase + 32'(gaddr[4:2])) : 32'h0));
            if (rv_now) beats++;
            if (fill_valid) begin
                chk({tag, " fill cycle"}, 256'(cyc), 256'(exp_cyc));
                chk({tag, " fill_addr"}, 256'(fill_addr), 256'(base));
                chk({tag, " fill_data"}, fill_data, exp_data);
                chk({tag, " words left"}, 256'(exp_addr_q.size()), 256'(0));
                done = 1'b1;
            end
            @(posedge CLK); #1;
            cyc++;
        end
        if (!done) begin
            chk({tag, " fill_valid timeout"}, 256'(0), 256'(1));
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0; miss_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk({tag, " after busy"}, 256'(busy), 256'(0));
            chk({tag, " after fill_valid"}, 256'(fill_valid), 256'(0));
            chk({tag, " held fill_data"}, fill_data, exp_data);
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        RST = 1'b1; miss_req = 1'b1; miss_addr = 32'h0000_0400;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        @(posedge CLK); @(posedge CLK); #1;
        chk_idle_outputs("reset");
        chk("reset fill_addr", 256'(fill_addr), 256'(0));
        chk("reset fill_data", fill_data, 256'(0));
        chk("reset crit_data", 256'(crit_data), 256'(0));
        miss_req = 1'b0;
        RST = 1'b0;
        @(posedge CLK); #1;

        run_line("basic", 32'h0000_0104, 32'hA000_0000, -1, 0, 17, 1'b0, 0);
        run_line("gnt_delay", 32'h0000_0104, 32'hA100_0000, 2, 3, 20, 1'b0, 0);
        run_line("stray", 32'h0000_0104, 32'hA200_0000, -1, 0, 17, 1'b1, 0);
        run_line("abort", 32'h0000_0140, 32'hA300_0000, -1, 0, 17, 1'b0, 4);
        run_line("after_abort", 32'h0000_0200, 32'hA400_0000, -1, 0, 17, 1'b0, 0);
        run_line("top_of_mem", 32'hFFFF_FFFC, 32'hA500_0000, -1, 0, 17, 1'b0, 0);
        run_line("crit", 32'h0000_0114, 32'hA600_0000, -1, 0, 17, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
